// File: rtl/en_ack_pkg.sv
// rtl/en_ack_pkg.sv - shared FSM state type and counter sizing for en_ack_responder
package en_ack_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Counter must hold values 0..WIDTH inclusive.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int ITER_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/en_ack_responder_shift_add_step.sv
// rtl/en_ack_responder_shift_add_step.sv - one combinational shift-add multiply iteration
module shift_add_step
    import en_ack_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc_next,
    output logic [2*WIDTH-1:0] a_next,
    output logic [WIDTH-1:0]   b_next
);

    always_comb begin
        acc_next = b[0] ? (acc + a) : acc;
        a_next   = a << 1;
        b_next   = b >> 1;
    end

endmodule

// File: rtl/en_ack_responder.sv
// rtl/en_ack_responder.sv - en/ack responder running an iterative shift-add multiply
// Optional macro EN_ACK_RESPONDER_EARLY_ZERO_EN: finish COMPUTE once the multiplier is exhausted.
module en_ack_responder
    import en_ack_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic               ack,
    output logic               busy,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = cnt_width(WIDTH);

    state_t             state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [CW-1:0]      iter;

    logic [2*WIDTH-1:0] acc_nx;
    logic [2*WIDTH-1:0] a_nx;
    logic [WIDTH-1:0]   b_nx;
    logic               last_step;

    shift_add_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .a        (a_reg),
        .b        (b_reg),
        .acc_next (acc_nx),
        .a_next   (a_nx),
        .b_next   (b_nx)
    );

`ifdef EN_ACK_RESPONDER_EARLY_ZERO_EN
    // Remaining iterations add nothing once b has shifted out to zero.
    assign last_step = (iter == CW'(WIDTH - 1)) || (b_nx == '0);
`else
    assign last_step = (iter == CW'(WIDTH - 1));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            iter    <= '0;
            ack     <= 1'b0;
            busy    <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ack <= 1'b0;
                    if (en) begin
                        a_reg <= {{WIDTH{1'b0}}, a_in};
                        b_reg <= b_in;
                        acc   <= '0;
                        iter  <= '0;
                        busy  <= 1'b1;
                        state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    acc   <= acc_nx;
                    a_reg <= a_nx;
                    b_reg <= b_nx;
                    iter  <= iter + 1'b1;
                    if (last_step) begin
                        product <= acc_nx;
                        ack     <= 1'b1;
                        state   <= ACK;
                    end
                end
                ACK: begin
                    ack   <= 1'b0;
                    busy  <= 1'b0;
                    state <= en ? RELEASE : IDLE;
                end
                RELEASE: begin
                    ack  <= 1'b0;
                    busy <= 1'b0;
                    // A held request must drop before another is accepted.
                    if (!en) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    ack   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
